// File: rtl/zclock_phase_ctrl_pkg.sv
// rtl/zclock_phase_ctrl_pkg.sv - shared Z80 speed codes and commit FSM state type
package zclock_phase_ctrl_pkg;

    localparam logic [1:0] TURBO_35  = 2'b00;
    localparam logic [1:0] TURBO_70  = 2'b01;
    localparam logic [1:0] TURBO_140 = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ctrl_state_t;

    // Both 2'b10 and 2'b11 select 14 MHz.
    function automatic logic is_turbo_140(input logic [1:0] code);
        return code[1];
    endfunction

endpackage

// File: rtl/zclock_phase_ctrl.sv
// rtl/zclock_phase_ctrl.sv - 7 MHz phase strobes and refresh-aligned CPU speed commit
module zclock_phase_ctrl
    import zclock_phase_ctrl_pkg::*;
#(
    parameter logic [1:0] TURBO_RST = TURBO_35,
    parameter int         TMO_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    input  logic       zpos,
    input  logic       rfsh_n,
    input  logic       cpu_rst_n,
    input  logic [1:0] turbo_req,
    output logic [1:0] turbo,
    output logic       turbo_pend,
    output logic       turbo_upd
);

    localparam logic [TMO_W-1:0] TMO_MAX  = '1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - TMO_W'(1);

    logic [1:0]       cnt;
    ctrl_state_t      state;
    logic [TMO_W-1:0] tmo_cnt;

    logic       req_diff;
    logic       rfsh_zpos;
    logic       tmo_hit;
    logic       commit;
    logic [1:0] turbo_nxt;

    always_comb begin
        req_diff  = (turbo_req != turbo);
        rfsh_zpos = zpos && !rfsh_n;
        // This zpos is the (2**TMO_W-1)-th one seen while waiting.
        tmo_hit   = zpos && (tmo_cnt >= TMO_LAST);
        commit    = (state == ST_WAIT) && req_diff &&
                    (!cpu_rst_n || rfsh_zpos || tmo_hit);
        turbo_nxt = commit ? turbo_req : turbo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
            c0  <= 1'b0;
            c1  <= 1'b0;
            c2  <= 1'b0;
            c3  <= 1'b0;
        end else begin
            cnt <= cnt + 2'd1;
            c0  <= (cnt == 2'd0);
            c1  <= (cnt == 2'd1);
            c2  <= (cnt == 2'd2);
            c3  <= (cnt == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            turbo      <= TURBO_RST;
            turbo_pend <= 1'b0;
            turbo_upd  <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            turbo      <= turbo_nxt;
            turbo_upd  <= commit;
            // Compared against the post-commit value so pend drops with the commit.
            turbo_pend <= (turbo_req != turbo_nxt);
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (req_diff)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (commit || !req_diff)
                        state <= ST_IDLE;
                    if (rfsh_zpos)
                        tmo_cnt <= '0;
                    else if (zpos && (tmo_cnt != TMO_MAX))
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
                default: begin
                    state   <= ST_IDLE;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

endmodule
